// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl
//   Sequencer for a universal shift register (sel 00 hold, 01 shift-left,
//   10 shift-right, 11 load). Runs one command at a time: serialize a
//   parallel word (TX) or assemble a word from serial bits (RX).
//
//   State | meaning
//   IDLE  | waiting for a command, cmd_ready=1
//   TX    | presenting the register's outgoing end bit on ser_out
//   RX    | shifting ser_in bits into the register
//   RDONE | assembled word held on rx_data until consumed
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op                        00 TX MSB-first, 01 TX LSB-first,
//                                 10 RX MSB-first, 11 RX LSB-first
//   cmd_data                      TX word
//   abort                         synchronous abort of the current command
//   ser_out/ser_out_valid/_ready  TX serial bit stream
//   ser_in/ser_in_valid           RX serial bit stream (no backpressure)
//   rx_data/rx_valid/rx_ready     assembled RX word
//   busy                          command in progress
//   sr_sel/sr_pi/sr_si            shift register controls
//   sr_po                         shift register parallel output
module shift_seq_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_out_valid,
  input  logic             ser_out_ready,
  input  logic             ser_in,
  input  logic             ser_in_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             busy,
  output logic [1:0]       sr_sel,
  output logic [WIDTH-1:0] sr_pi,
  output logic             sr_si,
  input  logic [WIDTH-1:0] sr_po
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TX    = 2'd1;
  localparam logic [1:0] S_RX    = 2'd2;
  localparam logic [1:0] S_RDONE = 2'd3;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LEFT  = 2'b01;
  localparam logic [1:0] SEL_RIGHT = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  logic [1:0]       state;
  logic             dir;
  logic [CNT_W-1:0] cnt;

  logic tx_fire;
  logic rx_bit;
  logic [1:0] shift_sel;

  // abort suppresses any same-cycle transfer
  assign tx_fire   = (state == S_TX) && ser_out_ready && !abort;
  assign rx_bit    = (state == S_RX) && ser_in_valid && !abort;
  assign shift_sel = dir ? SEL_RIGHT : SEL_LEFT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      dir   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            dir   <= cmd_op[0];
            cnt   <= '0;
            state <= cmd_op[1] ? S_RX : S_TX;
          end
        end
        S_TX: begin
          if (abort) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (tx_fire) begin
            if (cnt == CNT_LAST) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_RX: begin
          if (abort) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (rx_bit) begin
            if (cnt == CNT_LAST) begin
              // counter is not needed in RDONE; clearing it keeps it <= WIDTH-1
              state <= S_RDONE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          if (abort || rx_ready) begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

  assign rx_data = sr_po;

  always_comb begin
    cmd_ready     = 1'b0;
    ser_out       = 1'b0;
    ser_out_valid = 1'b0;
    rx_valid      = 1'b0;
    busy          = 1'b0;
    sr_sel        = SEL_HOLD;
    sr_pi         = '0;
    sr_si         = 1'b0;
    if (!rst) begin
      busy = (state != S_IDLE);
      case (state)
        S_IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            sr_sel = SEL_LOAD;
            // RX loads zero to clear the register before bits arrive
            sr_pi  = cmd_op[1] ? '0 : cmd_data;
          end
        end
        S_TX: begin
          ser_out_valid = 1'b1;
          // taken from PO rather than SO, which changes with sel
          ser_out = dir ? sr_po[0] : sr_po[WIDTH-1];
          if (abort) sr_sel = SEL_LOAD;
          else if (tx_fire) sr_sel = shift_sel;
        end
        S_RX: begin
          if (abort) begin
            sr_sel = SEL_LOAD;
          end else if (rx_bit) begin
            sr_sel = shift_sel;
            sr_si  = ser_in;
          end
        end
        default: begin
          rx_valid = 1'b1;
          if (abort) sr_sel = SEL_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         abort;
  logic         ser_out;
  logic         ser_out_valid;
  logic         ser_out_ready;
  logic         ser_in;
  logic         ser_in_valid;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         busy;
  logic [1:0]   sr_sel;
  logic [W-1:0] sr_pi;
  logic         sr_si;
  logic [W-1:0] sr_po;

  int errors = 0;
  int checks = 0;

  logic         exp_tx_q[$];
  logic [W-1:0] exp_rx_q[$];

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .abort(abort),
    .ser_out(ser_out), .ser_out_valid(ser_out_valid), .ser_out_ready(ser_out_ready),
    .ser_in(ser_in), .ser_in_valid(ser_in_valid),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy),
    .sr_sel(sr_sel), .sr_pi(sr_pi), .sr_si(sr_si), .sr_po(sr_po)
  );

  // Universal shift register the controller drives
  logic [W-1:0] sr_q;
  assign sr_po = sr_q;
  always @(posedge clk) begin
    if (rst) sr_q <= '0;
    else begin
      case (sr_sel)
        2'b01:   sr_q <= {sr_q[W-2:0], sr_si};
        2'b10:   sr_q <= {sr_si, sr_q[W-1:1]};
        2'b11:   sr_q <= sr_pi;
        default: sr_q <= sr_q;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // i-th bit on the wire of word w
  function automatic logic wire_bit(input logic [W-1:0] w, input logic lsb, input int i);
    return lsb ? w[i] : w[W-1-i];
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (ser_out_valid && ser_out_ready && !abort) begin
      if (exp_tx_q.size() == 0) chk("tx_unexpected", 1, 0);
      else chk("tx_bit", ser_out, exp_tx_q.pop_front());
    end
    if (rx_valid && rx_ready && !abort) begin
      if (exp_rx_q.size() == 0) chk("rx_unexpected", 1, 0);
      else chk("rx_word", rx_data, exp_rx_q.pop_front());
    end
  end

  // Called at posedge+1 with the DUT idle
  task automatic issue(input logic [1:0] op, input logic [W-1:0] data, input logic idle_abort);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    abort     = idle_abort;
    @(negedge clk);
    chk("accept_ready", cmd_ready, 1);
    chk("accept_busy", busy, 0);
    chk("accept_sel", sr_sel, 2'b11);
    chk("accept_pi", sr_pi, op[1] ? {W{1'b0}} : data);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  // mode: 0 ready always, 1 ready toggling 1/0, 2 random; abort_at<0 means no abort
  task automatic run_tx(input logic lsb, input logic [W-1:0] data, input int mode, input int abort_at);
    int n = 0;
    int cyc = 0;
    logic rdy;
    int nbits;
    nbits = (abort_at >= 0 && abort_at < W) ? abort_at : W;
    for (int i = 0; i < nbits; i++) exp_tx_q.push_back(wire_bit(data, lsb, i));
    issue({1'b0, lsb}, data, ($urandom_range(0, 3) == 0));
    while (n < W) begin
      if (cyc > 20 * W) begin
        chk("tx_timeout", 1, 0);
        break;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ser_out_ready = rdy;
      abort = (n == abort_at);
      @(negedge clk);
      chk("tx_valid", ser_out_valid, 1);
      chk("tx_busy", busy, 1);
      if (abort) begin
        chk("abort_sel", sr_sel, 2'b11);
        chk("abort_pi", sr_pi, 0);
      end else begin
        chk("tx_sel", sr_sel, rdy ? (lsb ? 2 : 1) : 0);
        if (!rdy) chk("tx_hold_bit", ser_out, wire_bit(data, lsb, n));
      end
      @(posedge clk); #1;
      cyc++;
      if (abort) break;
      if (rdy) n++;
    end
    abort = 1'b0;
    ser_out_ready = 1'b0;
    @(negedge clk);
    chk("tx_end_busy", busy, 0);
    chk("tx_end_ready", cmd_ready, 1);
    chk("tx_end_valid", ser_out_valid, 0);
    @(posedge clk); #1;
  endtask

  // seq bit i is the i-th bit sent on ser_in
  task automatic run_rx(input logic lsb, input logic [W-1:0] seq, input logic gaps,
                        input int hold, input logic poke);
    int n = 0;
    int cyc = 0;
    logic v;
    logic [W-1:0] word;
    word = '0;
    for (int i = 0; i < W; i++) begin
      if (lsb) word[i] = seq[i];
      else     word[W-1-i] = seq[i];
    end
    exp_rx_q.push_back(word);
    issue({1'b1, lsb}, W'($urandom), ($urandom_range(0, 3) == 0));
    while (n < W) begin
      if (cyc > 20 * W) begin
        chk("rx_timeout", 1, 0);
        break;
      end
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      ser_in_valid = v;
      ser_in = v ? seq[n] : 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rx_sel", sr_sel, v ? (lsb ? 2 : 1) : 0);
      if (v) chk("rx_si", sr_si, seq[n]);
      chk("rx_early_valid", rx_valid, 0);
      @(posedge clk); #1;
      cyc++;
      if (v) n++;
    end
    ser_in_valid = 1'($urandom_range(0, 1));
    ser_in = 1'($urandom_range(0, 1));
    rx_ready = 1'b0;
    cmd_valid = poke;
    cmd_op = 2'($urandom_range(0, 3));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("rdone_valid", rx_valid, 1);
      chk("rdone_data", rx_data, word);
      chk("rdone_cmd_ready", cmd_ready, 0);
      chk("rdone_sel", sr_sel, 0);
      chk("rdone_busy", busy, 1);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rx_ready = 1'b1;
    @(negedge clk);
    chk("rdone_valid_final", rx_valid, 1);
    @(posedge clk); #1;
    rx_ready = 1'b0;
    ser_in_valid = 1'b0;
    @(negedge clk);
    chk("rx_end_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_data = '1;
    abort = 1'b1;
    ser_out_ready = 1'b1;
    ser_in = 1'b1;
    ser_in_valid = 1'b1;
    rx_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_tx_valid", ser_out_valid, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel", sr_sel, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cmd_valid = 1'b0;
    abort = 1'b0;
    ser_out_ready = 1'b0;
    ser_in_valid = 1'b0;
    rx_ready = 1'b0;
    @(negedge clk);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;

    // Reset mid-TX after 2 bits
    exp_tx_q.push_back(1'b1);
    exp_tx_q.push_back(1'b0);
    issue(2'b00, 5'b10110, 1'b0);
    ser_out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx_valid", ser_out_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_busy", busy, 0);
    chk("postrst_ready", cmd_ready, 1);
    chk("postrst_sel", sr_sel, 0);
    chk("postrst_tx_valid", ser_out_valid, 0);
    @(posedge clk); #1;
    ser_out_ready = 1'b0;

    run_tx(1'b0, 5'b10110, 0, -1);          // MSB-first full rate
    run_tx(1'b1, 5'b10110, 1, -1);          // LSB-first, ready toggling

    // RX MSB-first, wire bits 1,1,0,0,1
    run_rx(1'b0, 5'b10011, 1'b1, 3, 1'b0);
    // RX LSB-first, wire bits 1,1,0,0,1, command offered in RDONE
    run_rx(1'b1, 5'b10011, 1'b0, 2, 1'b1);

    run_tx(1'b0, 5'b11010, 0, 3);           // abort after 3 bits
    run_rx(1'b0, 5'b01101, 1'b1, 1, 1'b0);  // following RX completes

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 0)
        run_tx(1'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 2),
               ($urandom_range(0, 4) == 0) ? $urandom_range(0, W - 1) : -1);
      else
        run_rx(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    chk("tx_queue_empty", exp_tx_q.size(), 0);
    chk("rx_queue_empty", exp_rx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
